r512x8_512x8_ram: RTL and testbench
===================================

# r512x8_512x8_ram

Single-clock, simple dual-port 512-word × 8-bit synchronous RAM with one write port and one registered read port. It is the packet buffer for the USB full-speed OUT protocol engine:
- The write port receives data bytes at address {endpoint[3:0], put_ptr[4:0]}.
- The read port returns bytes to the endpoint consumer at address {endpoint[3:0], get_ptr[4:0]}.

## Interface
Parameters:
- None. Depth is fixed at 512 words, data width at 8 bits, address width at 9 bits.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- reset  input  1  Synchronous, active-high reset.
- WA  input  9  Write address.
- WD  input  8  Write data.
- WEN  input  1  Write enable, active-high.
- WClk_En  input  1  Write-port clock enable; the write is suppressed when low.
- RA  input  9  Read address.
- RClk_En  input  1  Read-port clock enable; RD holds its value when low.
- RD  output  8  Registered read data.

## Operation
- Storage: array mem[0..511] of 8-bit words. There is no reset of the array contents; contents are undefined until written.
- Write: at a rising clk edge, mem[WA] <= WD when WEN=1, WClk_En=1 and reset=0. Otherwise the array is unchanged.
- Read: at a rising clk edge:
  - when reset=1: RD <= 8'h00;
  - else when RClk_En=1: RD <= mem[RA] (the value before any same-edge write);
  - else RD holds.
- Reset priority: reset dominates RClk_En and blocks writes in the same cycle.
- Read-during-write, same address, same edge: read-first. RD gets the old contents; the new data is visible on a read issued at the next edge.
- Read and write at different addresses in the same cycle are fully independent.
- Addresses are always in range (9 bits cover 0..511). There is no wrap logic and no out-of-range case.
- No full/empty tracking. Pointer management belongs to the protocol engine.

## Timing
- Write latency: data written at edge N is readable by a read issued at edge N+1, so it appears on RD after edge N+1.
- Read latency: 1 cycle. RA presented before edge N gives RD valid after edge N and stable until the next enabled edge.
- RD reset value: 8'h00. It is valid in the cycle after reset is sampled high.
- No combinational path from any input to RD.
- Mid-operation reset: RD clears at the next edge. Previously written array contents are retained, and a read issued after reset deasserts returns them.
- Enables are sampled per edge, with no multi-cycle handshake. WEN=1 with WClk_En=0 writes nothing.
- Must map to one 512x8 block RAM. The output register must be implementable as the RAM's read register.

## Test plan
- Basic write/read: write 8'hA5 to 9'h000 and 8'h3C to 9'h1FF in consecutive cycles, then read 9'h000 and 9'h1FF. RD = 8'hA5 one cycle after RA=0 is sampled, then 8'h3C.
- Full sweep: write mem[a] = a[7:0] ^ {a[8],7'h00} for a = 0..511, then read back all 512 addresses. Every RD matches exactly, with 1-cycle latency.
- Read-during-write: mem[9'h042]=8'h11. At one edge, write 8'h22 to 9'h042 and read 9'h042. RD = 8'h11. The next read of the same address gives RD = 8'h22.
- Enable gating:
  - WEN=1, WClk_En=0, write 8'hFF to 9'h010 (previously 8'h00). A later read returns 8'h00.
  - RClk_En=0 while RA changes. RD holds its previous value.
- Reset: after RD=8'h5A, assert reset for one cycle with RClk_En=1 and WEN=1 writing 8'h77 to 9'h020. RD = 8'h00 after that edge. A read of 9'h020 returns its pre-reset value, not 8'h77.
- Endpoint-layout use: write bytes 1,2,3 at {4'd1,5'd0..2} while reading {4'd0,5'd0..2} concurrently. The endpoint-0 data is unaffected, and endpoint-1 reads return 1,2,3.

Source files
------------

// File: rtl/r512x8_512x8_ram.sv
// 512 x 8 simple dual-port packet buffer for the USB full-speed OUT engine.
// One write port and one read-first, registered read port that maps onto a single block RAM.
module r512x8_512x8_ram (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] WA,
    input  logic [7:0] WD,
    input  logic       WEN,
    input  logic       WClk_En,
    input  logic [8:0] RA,
    input  logic       RClk_En,
    output logic [7:0] RD
);

    localparam int DATA_W = 8;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic              wr_en_p0;

    assign wr_en_p0 = WEN & WClk_En & ~reset;

    // Array contents carry no reset so the storage infers as block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_p0) begin
            mem[WA] <= WD;
        end
    end

    // Read register: read-first on collision, since mem[RA] is sampled before the write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            RD <= '0;
        end else if (RClk_En) begin
            RD <= mem[RA];
        end
    end

endmodule

// File: tb/tb_r512x8_512x8_ram.sv
// Scoreboard bench for r512x8_512x8_ram: directed scenarios plus randomized traffic,
// checked against an array-based reference model.
module tb_r512x8_512x8_ram;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] WA;
    logic [7:0] WD;
    logic       WEN;
    logic       WClk_En;
    logic [8:0] RA;
    logic       RClk_En;
    logic [7:0] RD;

    r512x8_512x8_ram dut (
        .clk     (clk),
        .reset   (reset),
        .WA      (WA),
        .WD      (WD),
        .WEN     (WEN),
        .WClk_En (WClk_En),
        .RA      (RA),
        .RClk_En (RClk_En),
        .RD      (RD)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         chk;
        logic [7:0] exp;
        string      tag;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] ref_mem [0:511];
    bit         ref_known [0:511];
    logic [7:0] rd_exp;
    bit         rd_known;
    int         errors = 0;
    int         checks = 0;
    bit         done = 1'b0;

    // One clock edge: drive at negedge, then update the model at the edge and queue the expected RD.
    task automatic cycle(input bit rst, input bit wen, input bit wce, input logic [8:0] wa,
                         input logic [7:0] wd, input bit ren, input logic [8:0] ra,
                         input string tag);
        exp_t e;
        @(negedge clk);
        reset = rst; WEN = wen; WClk_En = wce; WA = wa; WD = wd; RClk_En = ren; RA = ra;
        @(posedge clk);
        if (rst) begin
            rd_exp = 8'h00;
            rd_known = 1'b1;
        end else if (ren) begin
            rd_exp = ref_mem[ra];
            rd_known = ref_known[ra];
        end
        if (wen && wce && !rst) begin
            ref_mem[wa] = wd;
            ref_known[wa] = 1'b1;
        end
        e.chk = rd_known;
        e.exp = rd_exp;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic wr(input logic [8:0] a, input logic [7:0] d, input string tag);
        cycle(1'b0, 1'b1, 1'b1, a, d, 1'b0, 9'h000, tag);
    endtask

    task automatic rd(input logic [8:0] a, input string tag);
        cycle(1'b0, 1'b0, 1'b0, 9'h000, 8'h00, 1'b1, a, tag);
    endtask

    // Monitor: RD is stable 2 time units after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.chk) begin
                    checks++;
                    if (RD !== e.exp) begin
                        errors++;
                        $display("FAIL %s: RD=%02h expected=%02h at t=%0t", e.tag, RD, e.exp, $time);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            ref_mem[i] = 8'h00;
            ref_known[i] = 1'b0;
        end
        rd_exp = 8'h00;
        rd_known = 1'b0;
        reset = 1'b1; WEN = 1'b0; WClk_En = 1'b0; WA = '0; WD = '0; RClk_En = 1'b0; RA = '0;

        cycle(1'b1, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 9'h000, "reset_rd");
        cycle(1'b1, 1'b1, 1'b1, 9'h005, 8'hEE, 1'b1, 9'h005, "reset_rd2");

        // Basic write/read at both address extremes
        wr(9'h000, 8'hA5, "basic_wr0");
        wr(9'h1FF, 8'h3C, "basic_wr1");
        rd(9'h000, "basic_rd0");
        rd(9'h1FF, "basic_rd1ff");

        // Full sweep
        for (int a = 0; a < 512; a++) begin
            logic [8:0] av;
            av = 9'(a);
            wr(av, av[7:0] ^ {av[8], 7'h00}, "sweep_wr");
        end
        for (int a = 0; a < 512; a++) rd(9'(a), "sweep_rd");

        // Read-during-write at the same address returns old data
        wr(9'h042, 8'h11, "rdw_init");
        cycle(1'b0, 1'b1, 1'b1, 9'h042, 8'h22, 1'b1, 9'h042, "rdw_old");
        rd(9'h042, "rdw_new");

        // Write suppressed by WClk_En=0
        wr(9'h010, 8'h00, "gate_init");
        cycle(1'b0, 1'b1, 1'b0, 9'h010, 8'hFF, 1'b0, 9'h000, "gate_wr");
        rd(9'h010, "gate_wce");

        // RD holds while RClk_En=0 and RA moves
        wr(9'h033, 8'h9C, "hold_init");
        rd(9'h033, "hold_load");
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 9'(i * 37), "hold_rd");

        // Mid-operation reset: RD clears, write blocked, contents retained
        wr(9'h020, 8'h5A, "rst_init");
        rd(9'h020, "rst_pre");
        cycle(1'b1, 1'b1, 1'b1, 9'h020, 8'h77, 1'b1, 9'h020, "rst_clear");
        rd(9'h020, "rst_retain");

        // Endpoint layout: endpoint-1 writes concurrent with endpoint-0 reads
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 1'b1, {4'd1, 5'(i)}, 8'(i + 1), 1'b1, {4'd0, 5'(i)}, "ep0_rd");
        for (int i = 0; i < 3; i++) rd({4'd1, 5'(i)}, "ep1_rd");
        for (int i = 0; i < 3; i++) rd({4'd0, 5'(i)}, "ep0_reread");

        // Randomized traffic concentrated on a small window to provoke collisions
        for (int n = 0; n < 3000; n++) begin
            logic [8:0] wa, ra;
            wa = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa : 9'($urandom_range(0, 15));
            cycle(($urandom_range(0, 63) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                  wa, 8'($urandom), ($urandom_range(0, 3) != 0), ra, "random");
        end

        cycle(1'b0, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 9'h000, "drain");
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        if (!done) begin
            $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
            $fatal(1, "timeout");
        end
    end

endmodule
